// File: rtl/work_ctrl_seq.sv
// Node work controller: sweeps every neuron on each falling tik edge, issuing
// Vm addresses with valid/full backpressure and matching 3-D spike source IDs.
module work_ctrl_seq #(
  parameter int NNW        = 12,
  parameter int SW         = 24,
  parameter int CODE_WIDTH = 2,
  parameter int OVW        = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tik,
  input  logic                  config_enable,
  input  logic                  config_clear,
  input  logic [CODE_WIDTH-1:0] spike_code,
  input  logic [NNW-1:0]        neu_num,
  input  logic [NNW-1:0]        x_in,
  input  logic [NNW-1:0]        y_in,
  input  logic [SW/3-1:0]       z_in,
  input  logic [SW/3-1:0]       z_base,
  input  logic                  spk_out_full,
  output logic                  vld,
  output logic [NNW-1:0]        vm_addr,
  output logic                  clear,
  output logic [CODE_WIDTH-1:0] mode,
  output logic [SW-1:0]         neuid,
  output logic                  busy,
  output logic                  sweep_done,
  output logic                  clear_done,
  output logic [OVW-1:0]        overrun_cnt
);

  localparam int CW = SW / 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t         state, state_next;
  logic           t1, t2, t3;
  logic           pend_tik, pend_clr;
  logic [NNW-1:0] addr, x, y;
  logic [CW-1:0]  z_off, z_coord;

  logic start, clr_req, reserved, last, go_run, go_clear, tick_queued;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {t3, t2, t1} <= '0;
    else        {t3, t2, t1} <= {t2, t1, tik};
  end

  assign start       = t3 & ~t2 & config_enable;
  assign clr_req     = config_clear & ~config_enable;
  assign reserved    = (spike_code == CODE_WIDTH'(3));
  assign last        = vld && (addr == neu_num);
  assign go_run      = (state == ST_IDLE) && (state_next == ST_RUN);
  assign go_clear    = (state == ST_IDLE) && (state_next == ST_CLEAR);
  // A tick that cannot start a sweep now is queued; reserved-code ticks in IDLE are dropped.
  assign tick_queued = start && ((state != ST_IDLE) || go_clear);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (pend_clr || clr_req)                   state_next = ST_CLEAR;
        else if ((start || pend_tik) && !reserved) state_next = ST_RUN;
      end
      ST_RUN, ST_CLEAR: if (last) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    vld   = 1'b0;
    clear = 1'b0;
    case (state)
      ST_RUN:   vld = ~spk_out_full;
      ST_CLEAR: begin
        vld   = 1'b1;
        clear = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      mode       <= '0;
      sweep_done <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      busy       <= (state_next != ST_IDLE);
      sweep_done <= last && (state == ST_RUN);
      clear_done <= last && (state == ST_CLEAR);
      if (go_run) mode <= spike_code;
    end
  end

  // Neuron counters: x fastest, then y, then z offset; all zeroed after the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      x     <= '0;
      y     <= '0;
      z_off <= '0;
    end else if (last) begin
      addr  <= '0;
      x     <= '0;
      y     <= '0;
      z_off <= '0;
    end else if (vld) begin
      addr <= addr + NNW'(1);
      x    <= (x == x_in) ? '0 : x + NNW'(1);
      if (x == x_in) begin
        y <= (y == y_in) ? '0 : y + NNW'(1);
        if (y == y_in) z_off <= (z_off == z_in) ? '0 : z_off + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_tik    <= 1'b0;
      pend_clr    <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      if (!config_enable)              pend_tik <= 1'b0;
      else if (go_run)                 pend_tik <= 1'b0;
      else if (tick_queued)            pend_tik <= 1'b1;

      if (tick_queued && pend_tik && config_enable && (overrun_cnt != '1))
        overrun_cnt <= overrun_cnt + OVW'(1);

      if (go_clear)                              pend_clr <= 1'b0;
      else if ((state == ST_RUN) && clr_req)     pend_clr <= 1'b1;
    end
  end

  // Idle output is forced to zero so z_base does not leak out between sweeps.
  assign z_coord = z_base + z_off;
  assign vm_addr = addr;
  assign neuid   = (state != ST_IDLE) ? {z_coord, CW'(y), CW'(x)} : '0;

endmodule

// File: tb/tb_work_ctrl_seq.sv
// Directed bench for work_ctrl_seq: sweeps, backpressure, overrun, clear,
// z wrap, reserved code and mid-sweep reset.
module tb_work_ctrl_seq;

  localparam int NNW = 12, SW = 24, CODE_WIDTH = 2, OVW = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  tik = 1'b0;
  logic                  config_enable = 1'b1;
  logic                  config_clear = 1'b0;
  logic [CODE_WIDTH-1:0] spike_code = '0;
  logic [NNW-1:0]        neu_num = 12'd5, x_in = 12'd2, y_in = 12'd1;
  logic [7:0]            z_in = 8'd0, z_base = 8'd3;
  logic                  spk_out_full = 1'b0;
  logic                  vld, clear, busy, sweep_done, clear_done;
  logic [NNW-1:0]        vm_addr;
  logic [CODE_WIDTH-1:0] mode;
  logic [SW-1:0]         neuid;
  logic [OVW-1:0]        overrun_cnt;

  work_ctrl_seq #(.NNW(NNW), .SW(SW), .CODE_WIDTH(CODE_WIDTH), .OVW(OVW)) dut (
    .clk(clk), .rst_n(rst_n), .tik(tik), .config_enable(config_enable),
    .config_clear(config_clear), .spike_code(spike_code), .neu_num(neu_num),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .z_base(z_base),
    .spk_out_full(spk_out_full), .vld(vld), .vm_addr(vm_addr), .clear(clear),
    .mode(mode), .neuid(neuid), .busy(busy), .sweep_done(sweep_done),
    .clear_done(clear_done), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NNW-1:0] addr;
    logic [SW-1:0]  id;
    logic           clr;
  } beat_t;

  beat_t beats[$];
  int    n_cmp = 0, n_bad = 0;
  int    n_done, n_cdone, n_stall, n_wait;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] mk_id(input int z, input int y, input int x);
    return {z[7:0], y[7:0], x[7:0]};
  endfunction

  task automatic pulse_tik(input int hi, input int lo);
    @(negedge clk);
    tik = 1'b1;
    repeat (hi) @(negedge clk);
    tik = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_busy(input int budget);
    bit seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      #1;
      if (busy) seen = 1;
      else @(negedge clk);
    end
    check("wait_busy", 32'(seen), 32'd1);
  endtask

  // Records accepted beats until the first idle cycle after a sweep; full is
  // held high for stall_len cycles once stall_at beats have been accepted.
  task automatic collect(input int budget, input int stall_at, input int stall_len);
    int    left = stall_len;
    bit    in_sweep = 0, finished = 0;
    beat_t b;
    beats.delete();
    n_done = 0; n_cdone = 0; n_stall = 0; n_wait = 0;
    for (int c = 0; c < budget && !finished; c++) begin
      spk_out_full = (beats.size() == stall_at) && (left > 0);
      #1;
      if (spk_out_full) left--;
      if (busy) in_sweep = 1;
      if (!in_sweep) n_wait++;
      if (vld) begin
        b.addr = vm_addr; b.id = neuid; b.clr = clear;
        beats.push_back(b);
      end else if (busy) begin
        n_stall++;
        check("stall_hold_addr", 32'(vm_addr), 32'(stall_at));
      end
      n_done  += int'(sweep_done);
      n_cdone += int'(clear_done);
      if (in_sweep && !busy) finished = 1;
      else @(negedge clk);
    end
    spk_out_full = 1'b0;
    check("collect_finished", 32'(finished), 32'd1);
  endtask

  initial begin
    int xs[6] = '{0, 1, 2, 0, 1, 2};
    int ys[6] = '{0, 0, 0, 1, 1, 1};
    int zs[4] = '{255, 0, 255, 0};
    int busy_seen;

    // Reset state
    #2;
    check("rst_vld", 32'(vld), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_neuid", 32'(neuid), 0);
    check("rst_overrun", 32'(overrun_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // LIF sweep
    pulse_tik(3, 0);
    collect(20, -1, 0);
    check("lif_latency", 32'(n_wait inside {3, 4}), 1);
    check("lif_beats", beats.size(), 6);
    for (int i = 0; i < 6 && i < beats.size(); i++) begin
      check("lif_addr", 32'(beats[i].addr), 32'(i));
      check("lif_id", 32'(beats[i].id), 32'(mk_id(3, ys[i], xs[i])));
      check("lif_clr", 32'(beats[i].clr), 0);
    end
    check("lif_done", n_done, 1);
    check("lif_nostall", n_stall, 0);

    // Backpressure at addr 2 for 3 cycles
    pulse_tik(3, 0);
    collect(30, 2, 3);
    check("bp_beats", beats.size(), 6);
    for (int i = 0; i < 6 && i < beats.size(); i++)
      check("bp_addr", 32'(beats[i].addr), 32'(i));
    check("bp_stall_cycles", n_stall, 3);
    check("bp_done", n_done, 1);

    // Reserved code: tick discarded, not queued, not counted
    spike_code = 2'd3;
    pulse_tik(3, 0);
    busy_seen = 0;
    for (int c = 0; c < 10; c++) begin #1; busy_seen += int'(busy); @(negedge clk); end
    check("rsv_no_sweep", busy_seen, 0);
    spike_code = 2'd0;
    busy_seen = 0;
    for (int c = 0; c < 10; c++) begin #1; busy_seen += int'(busy); @(negedge clk); end
    check("rsv_not_queued", busy_seen, 0);
    check("rsv_overrun", 32'(overrun_cnt), 0);

    // z wrap with POISSON mode
    neu_num = 12'd3; x_in = 12'd0; y_in = 12'd0; z_in = 8'd1; z_base = 8'd255;
    spike_code = 2'd2;
    pulse_tik(3, 0);
    collect(20, -1, 0);
    check("z_beats", beats.size(), 4);
    for (int i = 0; i < 4 && i < beats.size(); i++)
      check("z_id", 32'(beats[i].id), 32'(mk_id(zs[i], 0, 0)));
    check("z_mode", 32'(mode), 2);

    // Overrun: 3 ticks during one long sweep
    neu_num = 12'd200; x_in = 12'd9; y_in = 12'd9; z_in = 8'd1; z_base = 8'd0;
    spike_code = 2'd0;
    pulse_tik(3, 0);
    wait_busy(10);
    repeat (3) pulse_tik(3, 4);
    #1;
    check("ovr_cnt2", 32'(overrun_cnt), 2);
    collect(300, -1, 0);
    check("ovr_first_done", n_done, 1);
    if (beats.size() > 0) check("ovr_first_last", 32'(beats[beats.size()-1].addr), 200);
    collect(300, -1, 0);
    check("ovr_back_to_back", n_wait, 1);
    check("ovr_second_beats", beats.size(), 201);
    if (beats.size() == 201) begin
      check("ovr_id123", 32'(beats[123].id), 32'(mk_id(1, 2, 3)));
      check("ovr_id200", 32'(beats[200].id), 32'(mk_id(0, 0, 0)));
    end
    check("ovr_cnt_hold", 32'(overrun_cnt), 2);

    // Saturation: stalled sweep, 300 ticks
    spike_code = 2'd1;
    pulse_tik(3, 0);
    wait_busy(10);
    spk_out_full = 1'b1;
    repeat (300) pulse_tik(1, 2);
    repeat (4) @(negedge clk);
    #1;
    check("sat_cnt", 32'(overrun_cnt), 255);
    check("sat_stalled_vld", 32'(vld), 0);
    check("sat_hold_addr", 32'(vm_addr), 0);
    check("sat_mode", 32'(mode), 1);

    // Reset mid-sweep clears everything, including the pending tick
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_mode", 32'(mode), 0);
    check("mrst_overrun", 32'(overrun_cnt), 0);
    check("mrst_neuid", 32'(neuid), 0);
    spk_out_full = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    for (int c = 0; c < 10; c++) begin #1; busy_seen += int'(busy); @(negedge clk); end
    check("mrst_pend_lost", busy_seen, 0);

    // Reset at beat 3, then restart from addr 0
    neu_num = 12'd5; x_in = 12'd2; y_in = 12'd1; z_in = 8'd0; z_base = 8'd3;
    spike_code = 2'd0;
    pulse_tik(3, 0);
    wait_busy(10);
    repeat (3) @(negedge clk);
    #1;
    check("b3_addr", 32'(vm_addr), 3);
    rst_n = 1'b0;
    #1;
    check("b3_rst_addr", 32'(vm_addr), 0);
    check("b3_rst_vld", 32'(vld), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_tik(3, 0);
    collect(20, -1, 0);
    check("b3_restart_beats", beats.size(), 6);
    if (beats.size() > 0) check("b3_restart_addr0", 32'(beats[0].addr), 0);

    // Clear with node disabled ignores full
    config_enable = 1'b0;
    @(negedge clk);
    config_clear = 1'b1;
    @(negedge clk);
    config_clear = 1'b0;
    collect(20, 1, 2);
    check("clr_beats", beats.size(), 6);
    for (int i = 0; i < 6 && i < beats.size(); i++) begin
      check("clr_addr", 32'(beats[i].addr), 32'(i));
      check("clr_flag", 32'(beats[i].clr), 1);
    end
    check("clr_nostall", n_stall, 0);
    check("clr_done", n_cdone, 1);
    check("clr_no_sweep_done", n_done, 0);

    // Clear raised mid-RUN follows directly after sweep_done
    config_enable = 1'b1;
    pulse_tik(3, 0);
    wait_busy(10);
    repeat (2) @(negedge clk);
    config_enable = 1'b0;
    config_clear  = 1'b1;
    @(negedge clk);
    config_clear  = 1'b0;
    collect(20, -1, 0);
    check("mid_sweep_done", n_done, 1);
    if (beats.size() > 0) check("mid_last_addr", 32'(beats[beats.size()-1].addr), 5);
    collect(20, -1, 0);
    check("mid_clear_direct", n_wait, 1);
    check("mid_clear_beats", beats.size(), 6);
    if (beats.size() > 0) check("mid_clear_flag", 32'(beats[0].clr), 1);
    check("mid_clear_done", n_cdone, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
